// File: rtl/branch_sequencer.sv
// Branch execution sequencer for the multi-cycle MIPS datapath: decodes the branch
// opcode, steps the ALU through target and compare, and counts taken branches.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; all strobes low
//   TARGET  | ALU computes PC + (offset << 2) into ALUOut
//   COMPARE | ALU subtracts A - B; conditional PC write from ALUOut
//   DONE    | one-cycle done pulse, then back to IDLE
module branch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        abort,
  input  logic        cond_in,
  output logic [1:0]  branch_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        aluout_write,
  output logic [1:0]  pc_source,
  output logic        pc_write_cond,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {IDLE, TARGET, COMPARE, DONE} seqState;

  seqState state, nextState;
  logic       opLegal;
  logic [1:0] opCtrl;
  logic       acceptStart;

  always_comb begin
    opLegal = 1'b1;
    opCtrl  = 2'b00;
    case (opcode)
      6'h04:   opCtrl = 2'b00;
      6'h07:   opCtrl = 2'b01;
      6'h06:   opCtrl = 2'b10;
      6'h05:   opCtrl = 2'b11;
      default: opLegal = 1'b0;
    endcase
  end

  // abort outranks start, so a start coinciding with abort is simply not taken
  assign acceptStart = (state == IDLE) && start && !abort;

  always_comb begin
    nextState     = state;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    aluout_write  = 1'b0;
    pc_source     = 2'b00;
    pc_write_cond = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = opLegal ? TARGET : DONE;
      end
      TARGET: begin
        alu_src_b    = 2'b11;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
        busy         = 1'b1;
        nextState    = COMPARE;
      end
      COMPARE: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b010;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        busy          = 1'b1;
        nextState     = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // The PC write in COMPARE still lands when abort is sampled there, so the
  // taken count follows the same edge regardless of abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_ctrl <= 2'b00;
      illegal     <= 1'b0;
      taken_count <= 16'h0000;
    end else begin
      if (acceptStart) begin
        illegal <= !opLegal;
        if (opLegal) branch_ctrl <= opCtrl;
      end
      if (state == COMPARE && cond_in && taken_count != 16'hFFFF)
        taken_count <= taken_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: an opcode vector table plus hand-written
// abort, start-hold, saturation and async-reset sequences.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        abort = 1'b0;
  logic        cond_in = 1'b0;
  logic [1:0]  branch_ctrl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        aluout_write;
  logic [1:0]  pc_source;
  logic        pc_write_cond;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] taken_count;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .abort(abort),
    .cond_in(cond_in), .branch_ctrl(branch_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .aluout_write(aluout_write),
    .pc_source(pc_source), .pc_write_cond(pc_write_cond), .busy(busy),
    .done(done), .illegal(illegal), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  // {alu_src_a, alu_src_b, alu_op, aluout_write, pc_source, pc_write_cond, busy, done}
  logic [11:0] strobes;
  assign strobes = {alu_src_a, alu_src_b, alu_op, aluout_write, pc_source,
                    pc_write_cond, busy, done};

  localparam logic [11:0] S_IDLE    = 12'b0_00_000_0_00_0_0_0;
  localparam logic [11:0] S_TARGET  = 12'b0_11_001_1_00_0_1_0;
  localparam logic [11:0] S_COMPARE = 12'b1_00_010_0_01_1_1_0;
  localparam logic [11:0] S_DONE    = 12'b0_00_000_0_00_0_1_1;

  typedef struct {
    logic [5:0] op;
    logic       cond;
    logic [1:0] ctrl;
    logic       ill;
  } vecT;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] expCount = 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input vecT v);
    start  = 1'b1;
    opcode = v.op;
    @(negedge clk);
    start = 1'b0;
    if (!v.ill) begin
      chk("target strobes", 16'(strobes), 16'(S_TARGET));
      chk("target ctrl", 16'(branch_ctrl), 16'(v.ctrl));
      chk("target illegal", 16'(illegal), 16'h0);
      cond_in = v.cond;
      @(negedge clk);
      chk("compare strobes", 16'(strobes), 16'(S_COMPARE));
      chk("compare ctrl", 16'(branch_ctrl), 16'(v.ctrl));
      if (v.cond && expCount != 16'hFFFF) expCount = expCount + 16'd1;
      @(negedge clk);
      cond_in = 1'b0;
    end
    chk("done strobes", 16'(strobes), 16'(S_DONE));
    chk("done illegal", 16'(illegal), 16'(v.ill));
    chk("done ctrl", 16'(branch_ctrl), 16'(v.ctrl));
    chk("taken count", taken_count, expCount);
    @(negedge clk);
    chk("idle strobes", 16'(strobes), 16'(S_IDLE));
    chk("idle ctrl", 16'(branch_ctrl), 16'(v.ctrl));
    chk("idle illegal", 16'(illegal), 16'(v.ill));
  endtask

  vecT vecs[10];
  vecT oneVec;
  int  doneSeen;

  initial begin
    vecs[0] = '{op: 6'h04, cond: 1'b1, ctrl: 2'b00, ill: 1'b0};
    vecs[1] = '{op: 6'h05, cond: 1'b0, ctrl: 2'b11, ill: 1'b0};
    vecs[2] = '{op: 6'h06, cond: 1'b0, ctrl: 2'b10, ill: 1'b0};
    vecs[3] = '{op: 6'h07, cond: 1'b0, ctrl: 2'b01, ill: 1'b0};
    vecs[4] = '{op: 6'h23, cond: 1'b0, ctrl: 2'b01, ill: 1'b1};
    vecs[5] = '{op: 6'h06, cond: 1'b1, ctrl: 2'b10, ill: 1'b0};
    vecs[6] = '{op: 6'h3F, cond: 1'b1, ctrl: 2'b10, ill: 1'b1};
    vecs[7] = '{op: 6'h07, cond: 1'b1, ctrl: 2'b01, ill: 1'b0};
    vecs[8] = '{op: 6'h00, cond: 1'b0, ctrl: 2'b01, ill: 1'b1};
    vecs[9] = '{op: 6'h04, cond: 1'b0, ctrl: 2'b00, ill: 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset strobes", 16'(strobes), 16'(S_IDLE));
    chk("reset ctrl", 16'(branch_ctrl), 16'h0);
    chk("reset illegal", 16'(illegal), 16'h0);
    chk("reset count", taken_count, 16'h0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) runVec(vecs[i]);

    // abort in TARGET: straight back to IDLE, no PC write, no done
    start = 1'b1; opcode = 6'h05;
    @(negedge clk);
    start = 1'b0;
    chk("abort target strobes", 16'(strobes), 16'(S_TARGET));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort idle strobes", 16'(strobes), 16'(S_IDLE));
    chk("abort ctrl latched", 16'(branch_ctrl), 16'h3);
    @(negedge clk);
    chk("abort stays idle", 16'(strobes), 16'(S_IDLE));

    // abort in COMPARE: this cycle's PC write and count update still happen
    start = 1'b1; opcode = 6'h04;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1; cond_in = 1'b1;
    chk("abort compare strobes", 16'(strobes), 16'(S_COMPARE));
    expCount = expCount + 16'd1;
    @(negedge clk);
    abort = 1'b0; cond_in = 1'b0;
    chk("abort compare idle", 16'(strobes), 16'(S_IDLE));
    chk("abort compare count", taken_count, expCount);

    // start held through the sequence with an illegal opcode: ignored
    start = 1'b1; opcode = 6'h07;
    doneSeen = 0;
    @(negedge clk);
    opcode = 6'h23;
    if (done) doneSeen++;
    @(negedge clk);
    if (done) doneSeen++;
    @(negedge clk);
    start = 1'b0;
    if (done) doneSeen++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    chk("held start done count", 16'(doneSeen), 16'h1);
    chk("held start ctrl", 16'(branch_ctrl), 16'h1);
    chk("held start illegal", 16'(illegal), 16'h0);

    // saturation: preload near the top, then two taken branches
    force dut.taken_count = 16'hFFFE;
    @(negedge clk);
    release dut.taken_count;
    @(negedge clk);
    chk("preload count", taken_count, 16'hFFFE);
    expCount = 16'hFFFE;
    oneVec = '{op: 6'h05, cond: 1'b1, ctrl: 2'b11, ill: 1'b0};
    runVec(oneVec);
    chk("count at max", taken_count, 16'hFFFF);
    runVec(oneVec);
    chk("count saturated", taken_count, 16'hFFFF);

    // async reset between edges while in COMPARE
    start = 1'b1; opcode = 6'h06;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cond_in = 1'b1;
    chk("pre-reset compare", 16'(strobes), 16'(S_COMPARE));
    #2 reset = 1'b1;
    #1;
    chk("async reset strobes", 16'(strobes), 16'(S_IDLE));
    chk("async reset ctrl", 16'(branch_ctrl), 16'h0);
    chk("async reset count", taken_count, 16'h0);
    chk("async reset illegal", 16'(illegal), 16'h0);
    @(negedge clk);
    chk("reset held no pc write", 16'(pc_write_cond), 16'h0);
    reset = 1'b0; cond_in = 1'b0;
    expCount = 16'h0;
    @(negedge clk);
    oneVec = '{op: 6'h07, cond: 1'b1, ctrl: 2'b01, ill: 1'b0};
    runVec(oneVec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
